ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 16-bit five-stage pipeline. It consumes the ID/EX pipeline bundle, which carries the ALU command, operand data, store data, destination register and control bits. It evaluates the ALU and registers the EX/MEM bundle for the memory stage. It also provides stall/flush control, registered ALU flags, and a retired-operation counter for debug.

## Interface
Parameters:
- `WIDTH`, 16: datapath width.
- `CNT_WIDTH`, 16: width of the operation counter.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `alu_cmd`  in  3: ALU command from ID/EX.
- `rs1_data`  in  WIDTH: operand A.
- `rs2_data`  in  WIDTH: operand B; for ADDI/LD/ST this is the sign-extended immediate.
- `store_data`  in  WIDTH: data for ST.
- `op_dest`  in  3: destination register.
- `mem_write_en`  in  1: ST marker.
- `wb_mux`  in  1: 1 = write back from memory (LD).
- `wb_en`  in  1: register write-back enable.
- `stall`  in  1: hold the EX/MEM register.
- `flush`  in  1: load a bubble into EX/MEM.
- `ex_mem_alu_result`  out  WIDTH: registered ALU result; this is the address for LD/ST.
- `ex_mem_store_data`  out  WIDTH: registered store data.
- `ex_mem_op_dest`  out  3: registered destination register.
- `ex_mem_mem_write_en`, `ex_mem_wb_mux`, `ex_mem_wb_en`  out  1 each: registered control bits.
- `ex_zero`  out  1: registered; result == 0.
- `ex_ovf`  out  1: registered; signed overflow (ADD/SUB only).
- `ex_fwd_result`  out  WIDTH: combinational ALU result, for forwarding.
- `op_count`  out  CNT_WIDTH: count of retired non-bubble operations.

## Operation
- ALU commands, operands A and B:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 NOR
  - 5 SLL (A<<B[3:0])
  - 6 SRL
  - 7 SRA (arithmetic, sign of A)
- Results wrap modulo 2^16.
- Shifts use only B[3:0]; B[15:4] is ignored.
- `ex_ovf`:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operands differ in sign and the result sign differs from A.
  - All other commands: 0.
- Bubble: the all-zero ID/EX bundle (ADD, wb_en=0, mem_write_en=0). It passes through with no side effects.
- A non-bubble operation is one with wb_en | mem_write_en.
- Per-edge priority, highest first:
  1. `rst`: all registered outputs and `op_count` go to 0.
  2. `flush`: all EX/MEM outputs, `ex_zero` and `ex_ovf` go to 0; `op_count` holds. Flush overrides stall.
  3. `stall`: all registers hold their values, including the counter.
  4. Otherwise: EX/MEM loads the ALU result and passes the bundle through. `op_count` increments if the incoming operation is non-bubble.
- `op_count` wraps from all-ones to 0.
- `ex_zero` and `ex_ovf` are computed from every loaded result, bubbles included.

## Timing
- Latency is one cycle: the bundle presented at edge N appears on `ex_mem_*` after edge N.
- `ex_fwd_result` is valid in the same cycle as its inputs. It has no register and does not depend on `stall` or `flush`.
- Reset is asynchronous: outputs clear immediately on `rst` rising, without waiting for a clock edge. This holds mid-stall too: a held value is lost.
- Release: after `rst` falls, the first rising edge performs a normal load.
- During stall the upstream bundle is not consumed. The ID stage must hold it.
- No handshake: the upstream must honour the stall.

## Structure
- Shared package (`pipe_pkg`):
  - ALU command constants (`ALU_ADD`…`ALU_SRA`).
  - Opcode constants NOP, ADDI=9, LD=10, ST=11, BZ=12, shared with ID.
  - Register-address width (3).
- Sub-module `alu16`: purely combinational; inputs A, B, cmd; outputs result and ovf.
- `ex_stage` contains only the register, the priority logic and the counter.

## Test plan
- Reset values: assert `rst` mid-operation with stall=1 → every output is 0 immediately, without waiting for a clock edge.
- ADD overflow: cmd=0, A=0x7FFF, B=0x0001, wb_en=1 → next cycle result=0x8000, ovf=1, zero=0, op_count=1.
- SUB to zero: cmd=1, A=0x1234, B=0x1234 → result=0, zero=1, ovf=0.
- SRA: cmd=7, A=0x8000, B=0x0013 → result=0xF000 (shift by 3).
- SLL: cmd=5, A=0x0001, B=0x0013 → result=0x0008.
- ST: cmd=0, A=0x0010, B=0xFFFE, store_data=0xBEEF, mem_write_en=1 → result=0x000E, store=0xBEEF, count+1.
- Stall and flush:
  - Load LD (dest=5, wb_mux=1), then stall 3 cycles with changing inputs → outputs frozen, count unchanged.
  - Then flush=1 together with stall=1 → all ex_mem outputs 0, count unchanged.
- Counter wrap: with CNT_WIDTH=4, issue 17 wb_en operations interleaved with bubbles → op_count=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU commands, opcodes and the register-address width.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package pipe_pkg;

  // Register file address width.
  localparam int REG_ADDR_W = 3;

  // ALU command encodings carried in the ID/EX bundle.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  // Instruction opcodes shared with the decode stage.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;

  // An operation retires (counts) when it writes a register or memory.
  function automatic logic is_retiring(input logic wb_en, input logic mem_write_en);
    return wb_en | mem_write_en;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational ALU for the execute stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b operands; cmd ALU command; result; ovf signed overflow (ADD/SUB only).
module alu16
  import pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cmd,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;

  assign sum   = a + b;
  assign diff  = a - b;
  // Only the low bits of B select the shift distance; upper bits are ignored.
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (cmd)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: evaluates the ALU and registers the EX/MEM bundle, flags and retire counter.
// Latency: 1 cycle ID/EX -> EX/MEM; ex_fwd_result is combinational (0 cycles).
// Backpressure: stall holds every register (upstream must hold its bundle); flush loads a bubble.
// Ports: ID/EX bundle in (alu_cmd, rs1/rs2/store data, op_dest, control bits), stall/flush,
//        EX/MEM bundle out, ex_zero/ex_ovf flags, ex_fwd_result forwarding path, op_count.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            alu_cmd,
  input  logic [WIDTH-1:0]      rs1_data,
  input  logic [WIDTH-1:0]      rs2_data,
  input  logic [WIDTH-1:0]      store_data,
  input  logic [REG_ADDR_W-1:0] op_dest,
  input  logic                  mem_write_en,
  input  logic                  wb_mux,
  input  logic                  wb_en,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      ex_mem_alu_result,
  output logic [WIDTH-1:0]      ex_mem_store_data,
  output logic [REG_ADDR_W-1:0] ex_mem_op_dest,
  output logic                  ex_mem_mem_write_en,
  output logic                  ex_mem_wb_mux,
  output logic                  ex_mem_wb_en,
  output logic                  ex_zero,
  output logic                  ex_ovf,
  output logic [WIDTH-1:0]      ex_fwd_result,
  output logic [CNT_WIDTH-1:0]  op_count
);

  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  alu16 #(.WIDTH(WIDTH)) u_alu (
    .a      (rs1_data),
    .b      (rs2_data),
    .cmd    (alu_cmd),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // Forwarding taps the ALU directly, independent of stall/flush.
  assign ex_fwd_result = alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_alu_result   <= '0;
      ex_mem_store_data   <= '0;
      ex_mem_op_dest      <= '0;
      ex_mem_mem_write_en <= 1'b0;
      ex_mem_wb_mux       <= 1'b0;
      ex_mem_wb_en        <= 1'b0;
      ex_zero             <= 1'b0;
      ex_ovf              <= 1'b0;
      op_count            <= '0;
    end else if (flush) begin
      // Flush wins over stall; the counter keeps its value.
      ex_mem_alu_result   <= '0;
      ex_mem_store_data   <= '0;
      ex_mem_op_dest      <= '0;
      ex_mem_mem_write_en <= 1'b0;
      ex_mem_wb_mux       <= 1'b0;
      ex_mem_wb_en        <= 1'b0;
      ex_zero             <= 1'b0;
      ex_ovf              <= 1'b0;
    end else if (!stall) begin
      ex_mem_alu_result   <= alu_result;
      ex_mem_store_data   <= store_data;
      ex_mem_op_dest      <= op_dest;
      ex_mem_mem_write_en <= mem_write_en;
      ex_mem_wb_mux       <= wb_mux;
      ex_mem_wb_en        <= wb_en;
      // Flags follow every loaded result, bubbles included.
      ex_zero             <= (alu_result == '0);
      ex_ovf              <= alu_ovf;
      if (is_retiring(wb_en, mem_write_en)) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    alu_cmd;
  logic [W-1:0]  rs1_data, rs2_data, store_data;
  logic [2:0]    op_dest;
  logic          mem_write_en, wb_mux, wb_en, stall, flush;
  logic [W-1:0]  ex_mem_alu_result, ex_mem_store_data, ex_fwd_result;
  logic [2:0]    ex_mem_op_dest;
  logic          ex_mem_mem_write_en, ex_mem_wb_mux, ex_mem_wb_en, ex_zero, ex_ovf;
  logic [CW-1:0] op_count;

  ex_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_cmd             (alu_cmd),
    .rs1_data            (rs1_data),
    .rs2_data            (rs2_data),
    .store_data          (store_data),
    .op_dest             (op_dest),
    .mem_write_en        (mem_write_en),
    .wb_mux              (wb_mux),
    .wb_en               (wb_en),
    .stall               (stall),
    .flush               (flush),
    .ex_mem_alu_result   (ex_mem_alu_result),
    .ex_mem_store_data   (ex_mem_store_data),
    .ex_mem_op_dest      (ex_mem_op_dest),
    .ex_mem_mem_write_en (ex_mem_mem_write_en),
    .ex_mem_wb_mux       (ex_mem_wb_mux),
    .ex_mem_wb_en        (ex_mem_wb_en),
    .ex_zero             (ex_zero),
    .ex_ovf              (ex_ovf),
    .ex_fwd_result       (ex_fwd_result),
    .op_count            (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [W-1:0]  sd;
    logic [2:0]    dest;
    logic          mw, wbm, wbe, zero, ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t model;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU from arithmetic definitions, using 32-bit signed ints.
  function automatic void ref_alu(input logic [2:0] cmd, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic v);
    int sa, sb, x, sh;
    sa = a[15] ? int'(a) - 65536 : int'(a);
    sb = b[15] ? int'(b) - 65536 : int'(b);
    sh = int'(b) % 16;
    v  = 1'b0;
    case (cmd)
      3'd0: begin x = sa + sb; v = (x > 32767) || (x < -32768); end
      3'd1: begin x = sa - sb; v = (x > 32767) || (x < -32768); end
      3'd2: x = int'(a & b);
      3'd3: x = int'(a | b);
      3'd4: x = 65535 - int'(a | b);
      3'd5: x = int'(a) * (1 << sh);
      3'd6: x = int'(a) / (1 << sh);
      default: x = sa >>> sh;
    endcase
    r = W'(x & 32'hFFFF);
  endfunction

  task automatic model_reset();
    model = '{res: '0, sd: '0, dest: '0, mw: 0, wbm: 0, wbe: 0, zero: 0, ovf: 0, cnt: '0};
  endtask

  task automatic step(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] sd, input logic [2:0] d, input logic mw,
                      input logic wbm, input logic wbe, input logic st, input logic fl);
    logic [W-1:0] r;
    logic         v;
    @(negedge clk);
    alu_cmd = c; rs1_data = a; rs2_data = b; store_data = sd; op_dest = d;
    mem_write_en = mw; wb_mux = wbm; wb_en = wbe; stall = st; flush = fl;
    ref_alu(c, a, b, r, v);
    #1 chk("fwd_result", int'(ex_fwd_result), int'(r));
    @(posedge clk);
    if (fl) begin
      model = '{res: '0, sd: '0, dest: '0, mw: 0, wbm: 0, wbe: 0, zero: 0, ovf: 0,
                cnt: model.cnt};
    end else if (!st) begin
      model.res = r; model.sd = sd; model.dest = d; model.mw = mw; model.wbm = wbm;
      model.wbe = wbe; model.zero = (r == 0); model.ovf = v;
      if (wbe || mw) model.cnt = CW'((int'(model.cnt) + 1) % (1 << CW));
    end
    #1 sb_q.push_back(model);
  endtask

  task automatic bubble();
    step(3'd0, '0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_result"}, int'(ex_mem_alu_result), 0);
    chk({tag, "_store"},  int'(ex_mem_store_data), 0);
    chk({tag, "_dest"},   int'(ex_mem_op_dest), 0);
    chk({tag, "_ctrl"},   int'({ex_mem_mem_write_en, ex_mem_wb_mux, ex_mem_wb_en}), 0);
    chk({tag, "_flags"},  int'({ex_zero, ex_ovf}), 0);
    chk({tag, "_count"},  int'(op_count), 0);
  endtask

  // Asynchronous reset asserted between edges while stalled.
  task automatic mid_stall_reset();
    @(negedge clk);
    stall = 1'b1; flush = 1'b0;
    rs1_data = W'($urandom); rs2_data = W'($urandom); wb_en = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every registered output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alu_result", int'(ex_mem_alu_result), int'(e.res));
        chk("store_data", int'(ex_mem_store_data), int'(e.sd));
        chk("op_dest",    int'(ex_mem_op_dest), int'(e.dest));
        chk("mem_wr_en",  int'(ex_mem_mem_write_en), int'(e.mw));
        chk("wb_mux",     int'(ex_mem_wb_mux), int'(e.wbm));
        chk("wb_en",      int'(ex_mem_wb_en), int'(e.wbe));
        chk("zero",       int'(ex_zero), int'(e.zero));
        chk("ovf",        int'(ex_ovf), int'(e.ovf));
        chk("op_count",   int'(op_count), int'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu_cmd = '0; rs1_data = '0; rs2_data = '0; store_data = '0; op_dest = '0;
    mem_write_en = 0; wb_mux = 0; wb_en = 0; stall = 0; flush = 0;
    model_reset();
    #3 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    step(3'd0, 16'h7FFF, 16'h0001, 16'h0000, 3'd1, 0, 0, 1, 0, 0);  // ADD overflow
    step(3'd1, 16'h1234, 16'h1234, 16'h0000, 3'd2, 0, 0, 1, 0, 0);  // SUB to zero
    step(3'd7, 16'h8000, 16'h0013, 16'h0000, 3'd3, 0, 0, 1, 0, 0);  // SRA by 3
    step(3'd5, 16'h0001, 16'h0013, 16'h0000, 3'd4, 0, 0, 1, 0, 0);  // SLL by 3
    step(3'd0, 16'h0010, 16'hFFFE, 16'hBEEF, 3'd0, 1, 0, 0, 0, 0);  // ST address
    step(3'd1, 16'h8000, 16'h0001, 16'h0000, 3'd6, 0, 0, 1, 0, 0);  // SUB overflow
    step(3'd0, 16'h0020, 16'h0004, 16'h0000, 3'd5, 0, 1, 1, 0, 0);  // LD
    for (int i = 0; i < 3; i++)
      step(3'(i + 2), W'($urandom), W'($urandom), W'($urandom), 3'(i), 1, 0, 1, 1, 0);
    step(3'd3, 16'hFFFF, 16'h0000, 16'h1111, 3'd7, 1, 1, 1, 1, 1);  // flush beats stall
    mid_stall_reset();

    // Counter wrap: 17 writes interleaved with bubbles -> count returns to 1.
    for (int i = 0; i < 17; i++) begin
      step(3'(i % 8), W'($urandom), W'($urandom), '0, 3'(i % 8), 0, 0, 1, 0, 0);
      bubble();
    end
    #3 chk("count_wrap", int'(op_count), 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) bubble();
      else
        step(3'($urandom), W'($urandom), W'($urandom), W'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end
    mid_stall_reset();
    for (int i = 0; i < 20; i++)
      step(3'($urandom), W'($urandom), W'($urandom), W'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #3 chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
